// File: rtl/vga_rom_reader.sv
// VGA timing generator and image ROM reader.
// Produces 640x480@60 timing from a divided system clock, addresses an
// 80x60 ROM with 8x nearest-neighbour upscale, and outputs RGB/sync/de
// through a two-stage pipeline so every output refers to the same pixel.
module vga_rom_reader #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int IMG_W       = 80,
  parameter int SCALE_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic [12:0] addr,
  input  logic [23:0] pixel_in,
  output logic [23:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic          pix_en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic          vis0, hs0, vs0, fs0;
  logic [12:0]   row, col, row_base, addr0;

  logic          vis1, hs1, vs1, fs1;

  assign pix_en = (div_cnt == DIV_LAST);

  // Pixel-rate divider: one pix_en pulse every CLK_DIV clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  // Horizontal / vertical position counters, advanced once per pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign vis0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs0  = !((h_cnt >= H_SS) && (h_cnt < H_SE));
  assign vs0  = !((v_cnt >= V_SS) && (v_cnt < V_SE));
  assign fs0  = (h_cnt == '0) && (v_cnt == '0);

  assign row = 13'(v_cnt >> SCALE_SHIFT);
  assign col = 13'(h_cnt >> SCALE_SHIFT);

  // Row base address; the 80-word case is a plain shift-add.
  generate
    if (IMG_W == 80) begin : g_mul80
      assign row_base = (row << 6) + (row << 4);
    end else begin : g_mul
      assign row_base = row * 13'(IMG_W);
    end
  endgenerate

  assign addr0 = vis0 ? (row_base + col) : '0;

  // Stage 1: ROM address plus the sync/visibility flags that travel with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      vis1 <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      fs1  <= 1'b0;
    end else if (pix_en) begin
      addr <= addr0;
      vis1 <= vis0;
      hs1  <= hs0;
      vs1  <= vs0;
      fs1  <= fs0;
    end
  end

  // Stage 2: capture ROM data and emit all outputs together; frame_start
  // is a single-clock pulse rather than a held pixel-rate level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en & fs1;
      if (pix_en) begin
        rgb   <= vis1 ? pixel_in : '0;
        hsync <= hs1;
        vsync <= vs1;
        de    <= vis1;
      end
    end
  end

endmodule

// File: tb/tb_vga_rom_reader.sv
// Self-checking bench for vga_rom_reader with a reduced vertical timing
// so several frames fit in a short run. Expected outputs are derived from
// the count of clocks since reset release.
module tb_vga_rom_reader;

  localparam int CLK_DIV     = 2;
  localparam int H_ACTIVE    = 640;
  localparam int H_FP        = 8;
  localparam int H_SYNC      = 8;
  localparam int H_BP        = 8;
  localparam int V_ACTIVE    = 16;
  localparam int V_FP        = 2;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 2;
  localparam int IMG_W       = 80;
  localparam int SCALE_SHIFT = 3;

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TOT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] addr;
  logic [23:0] pixel_in;
  logic [23:0] rgb;
  logic        hsync, vsync, de, frame_start;

  logic [23:0] rom [0:8191];
  logic        junk;
  int          k;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          fs_ks[$];

  always #5 clk = ~clk;

  assign pixel_in = junk ? 24'hFFFFFF : rom[addr];

  vga_rom_reader #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
    .H_BP(H_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
    .V_BP(V_BP), .IMG_W(IMG_W), .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .pixel_in(pixel_in), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (clk %0d)", tag, got, exp, k);
    end
  endtask

  // Screen position -> ROM word, straight from the upscale rule.
  function automatic int exp_addr(input int pos);
    int h, v;
    h = pos % HT;
    v = pos / HT;
    if (h < H_ACTIVE && v < V_ACTIVE)
      return (v / (1 << SCALE_SHIFT)) * IMG_W + (h / (1 << SCALE_SHIFT));
    return 0;
  endfunction

  task automatic check_reset_vals(input string ph);
    check_val({ph, "_addr"},  32'(addr), 32'd0);
    check_val({ph, "_rgb"},   32'(rgb), 32'd0);
    check_val({ph, "_de"},    32'(de), 32'd0);
    check_val({ph, "_hsync"}, 32'(hsync), 32'd1);
    check_val({ph, "_vsync"}, 32'(vsync), 32'd1);
    check_val({ph, "_fs"},    32'(frame_start), 32'd0);
  endtask

  // After n pixel ticks the counters sit at position n, the address stage
  // holds position n-1 and the output stage holds position n-2.
  task automatic check_cycle();
    int n, q, h, v, e_addr;
    logic [23:0] e_rgb;
    logic e_hs, e_vs, e_de, e_fs;
    n      = k / CLK_DIV;
    e_addr = (n >= 1) ? exp_addr((n - 1) % TOT) : 0;
    e_rgb  = '0;
    e_hs   = 1'b1;
    e_vs   = 1'b1;
    e_de   = 1'b0;
    e_fs   = 1'b0;
    if (n >= 2) begin
      q    = (n - 2) % TOT;
      h    = q % HT;
      v    = q / HT;
      e_de = (h < H_ACTIVE) && (v < V_ACTIVE);
      if (e_de) e_rgb = junk ? 24'hFFFFFF : rom[exp_addr(q)];
      e_hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
      e_vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      e_fs = (q == 0) && (k % CLK_DIV == 0);
    end
    check_val("addr",  32'(addr), 32'(e_addr));
    check_val("rgb",   32'(rgb), 32'(e_rgb));
    check_val("de",    32'(de), 32'(e_de));
    check_val("hsync", 32'(hsync), 32'(e_hs));
    check_val("vsync", 32'(vsync), 32'(e_vs));
    check_val("fs",    32'(frame_start), 32'(e_fs));
    if (frame_start) fs_ks.push_back(k);
  endtask

  task automatic step(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      k++;
      #1;
      check_cycle();
    end
  endtask

  task automatic check_frame_period(input string ph);
    if (fs_ks.size() >= 2) begin
      check_val({ph, "_fs_first"},  32'(fs_ks[0]), 32'(2 * CLK_DIV));
      check_val({ph, "_fs_period"}, 32'(fs_ks[1] - fs_ks[0]), 32'(TOT * CLK_DIV));
    end else begin
      check_val({ph, "_fs_count"}, 32'(fs_ks.size()), 32'd2);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 24'($urandom);
    junk = 1'b0;
    k    = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");

    @(negedge clk);
    rst = 1'b1;
    k   = 0;
    // One full frame, then on into the next until the counters reach h=300, v=10.
    step((TOT + 10 * HT + 300) * CLK_DIV);
    check_frame_period("p1");

    #($urandom_range(1, 2));
    rst = 1'b0;
    #1;
    check_reset_vals("mid");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("hold");

    @(negedge clk);
    junk = 1'b1;
    rst  = 1'b1;
    k    = 0;
    fs_ks.delete();
    step(TOT * CLK_DIV + 200);
    check_frame_period("p2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_rom_reader.md
Name: vga_rom_reader

Overview:
- Display-side initiator for the 80x60, 24-bit image ROM: generates 640x480@60 VGA timing.
- Computes the 13-bit ROM address for each visible pixel, with 8x nearest-neighbour upscale: each ROM word covers an 8x8 block of screen pixels.
- Captures the returned 24-bit pixel and drives RGB, sync and data-enable outputs, all aligned.
- Sits between the image ROM (combinational read, data valid in the same clk as the address) and the VGA DAC/pins.

Parameters:
- CLK_DIV, 4, system clocks per pixel. Must be >=2; the 100 MHz clock gives a 25 MHz pixel rate.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- IMG_W, 80, ROM image width (words per image row).
- SCALE_SHIFT, 3, log2 of the upscale factor.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock, reset is asynchronous and active-low (rst=0 resets)
- addr  output  13  ROM read address
- pixel_in  input  24  ROM data for addr, valid in the same clk
- rgb  output  24  pixel to DAC, {R[23:16],G[15:8],B[7:0]}
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- de  output  1  data enable, 1 in the visible region
- frame_start  output  1  one-clk pulse when the first visible pixel (0,0) appears on the outputs

Behaviour:
- Reset (async on rst falling; held while rst=0): div_cnt=0, h_cnt=0, v_cnt=0, all pipeline registers cleared. Output values: addr=0, rgb=0, hsync=1, vsync=1, de=0, frame_start=0.
- Pixel enable:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 for one clk when div_cnt==CLK_DIV-1, i.e. the first pix_en is in the CLK_DIV-th clk after reset release.
  - All counter and pipeline updates occur only on clk edges with pix_en=1.
- Counters:
  - H_TOTAL=800, V_TOTAL=525 (sums of the H_* and V_* parameters).
  - h_cnt increments 0..H_TOTAL-1. On wrap to 0, v_cnt increments 0..V_TOTAL-1 and wraps.
  - At (H_TOTAL-1, V_TOTAL-1) both counters go to 0 on the same edge.
- Stage 0, counters → stage 1, registered on pix_en:
  - vis1 = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - addr = vis1 ? (v_cnt>>SCALE_SHIFT)*IMG_W + (h_cnt>>SCALE_SHIFT) : 0.
  - The multiply by 80 is implemented as (r<<6)+(r<<4), truncated to 13 bits.
  - hs1 = !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), i.e. low for h 656..751.
  - vs1 = !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), i.e. low for lines 490..491.
  - fs1 = (h_cnt==0 && v_cnt==0).
- Stage 2, registered on pix_en:
  - rgb = vis1 ? pixel_in : 0.
  - hsync=hs1, vsync=vs1, de=vis1.
  - frame_start asserts for the single clk following the pix_en edge that loads fs1=1, then returns to 0.
- Latency and alignment:
  - Outputs lag the counters by 2 pixel periods (2*CLK_DIV clks).
  - rgb, hsync, vsync and de always refer to the same counter position.
  - No mixed-stage glitches are permitted.
- addr range: 0..4799 during visible pixels, never exceeds 4799, and is 0 in blanking.
- Stability: addr is stable for CLK_DIV clks, so a combinational ROM settles before capture.
- Reset mid-frame: all outputs go immediately to their reset values. After release the timing restarts from (0,0), with the first visible pixel at output 2 pixel periods after the first pix_en.
- pixel_in is ignored (rgb forced to 0) whenever vis1=0.

Test Plan:
- Reset release, CLK_DIV=4 → first pix_en on 4th clk; addr=0 after 1st pix_en; de=1 and frame_start=1 pulse after 2nd pix_en; hsync=vsync=1.
- Line walk → addr=0 for h=0..7, addr=1 at h=8, addr=79 at h=632..639, addr=0 for h>=640; row v=8 begins at addr=80; (639,479) gives addr=4799.
- Sync timing → hsync low exactly 96 pixel periods (384 clks) per 3200-clk line; vsync low for 2 lines (6400 clks) per 525-line frame; frame_start period 1,680,000 clks.
- ROM echo model pixel_in = {11'h0,addr} → rgb equals the address captured one pixel earlier whenever de=1; rgb=0 whenever de=0, even with pixel_in=24'hFFFFFF.
- Assert rst=0 mid-line (h=300, v=200) → outputs immediately rgb=0, de=0, hsync=1, vsync=1, addr=0; after release the full sequence restarts from (0,0).
- Alignment check → de rises on the same clk hsync/vsync reflect h=0; the de falling edge precedes the hsync falling edge by 16 pixel periods.
